// File: rtl/key_reader.sv
// Key read sequencer: once a full key set has been loaded, walks key slots 0..NUM_KEYS-1
// and hands each key word to the cipher core over a valid/ready handshake.
module key_reader #(
   parameter int IDX_W     = 2,
   parameter int KEY_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 key_rollover,
   input  logic                 key_clear,
   input  logic                 start,
   input  logic [KEY_WIDTH-1:0] key_data,
   output logic [IDX_W-1:0]     rd_index,
   output logic [KEY_WIDTH-1:0] key_out,
   output logic                 key_valid,
   input  logic                 key_ready,
   output logic                 key_last,
   output logic                 busy,
   output logic                 done,
   output logic                 error
);

   localparam logic [IDX_W-1:0] LAST_IDX = '1;

   typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

   state_t state;
   logic   keys_loaded;

   assign key_last = key_valid && (rd_index == LAST_IDX);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         rd_index    <= '0;
         key_out     <= '0;
         key_valid   <= 1'b0;
         keys_loaded <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;

         if (key_clear)
            keys_loaded <= 1'b0;
         else if (key_rollover)
            keys_loaded <= 1'b1;

         // A clear aborts any running sequence silently; no done pulse follows.
         if (key_clear && state != IDLE) begin
            state     <= IDLE;
            key_valid <= 1'b0;
            rd_index  <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (start && keys_loaded && !key_clear) begin
                     state    <= FETCH;
                     rd_index <= '0;
                  end else if (start && !keys_loaded) begin
                     error <= 1'b1;
                  end
               end
               FETCH: begin
                  key_out   <= key_data;
                  key_valid <= 1'b1;
                  state     <= PRESENT;
               end
               PRESENT: begin
                  if (key_valid && key_ready) begin
                     key_valid <= 1'b0;
                     if (rd_index == LAST_IDX) begin
                        state <= DONE;
                        done  <= 1'b1;
                     end else begin
                        rd_index <= rd_index + 1'b1;
                        state    <= FETCH;
                     end
                  end
               end
               DONE: begin
                  rd_index <= '0;
                  state    <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_key_reader.sv
// Bench for key_reader: scoreboard of expected key words plus per-scenario timing checks.
module tb_key_reader;

   logic        clk;
   logic        rst;
   logic        key_rollover;
   logic        key_clear;
   logic        start;
   logic [31:0] key_data;
   logic [1:0]  rd_index;
   logic [31:0] key_out;
   logic        key_valid;
   logic        key_ready;
   logic        key_last;
   logic        busy;
   logic        done;
   logic        error;

   logic [31:0] keyfile [4];
   logic [31:0] sb [$];
   logic [31:0] exp_key;
   int          n_cmp;
   int          n_bad;

   key_reader #(.IDX_W(2), .KEY_WIDTH(32)) dut (
      .clk(clk),
      .rst(rst),
      .key_rollover(key_rollover),
      .key_clear(key_clear),
      .start(start),
      .key_data(key_data),
      .rd_index(rd_index),
      .key_out(key_out),
      .key_valid(key_valid),
      .key_ready(key_ready),
      .key_last(key_last),
      .busy(busy),
      .done(done),
      .error(error)
   );

   assign key_data = keyfile[rd_index];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every accepted handshake must deliver the next expected key word.
   always @(posedge clk) begin
      if (!rst && key_valid && key_ready) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL sb_underflow: got key %0h, expected no transfer", key_out);
         end else begin
            exp_key = sb.pop_front();
            if (key_out !== exp_key) begin
               n_bad++;
               $display("FAIL sb_key: got %0h, expected %0h", key_out, exp_key);
            end
         end
      end
   end

   task automatic push_set();
      for (int i = 0; i < 4; i++) sb.push_back(keyfile[i]);
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_cmp++;
      if (key_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || key_last !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_ctrl: got v=%b b=%b d=%b e=%b l=%b, expected all 0", key_valid, busy, done, error, key_last);
      end
      n_cmp++;
      if (key_out !== 32'h0 || rd_index !== 2'd0) begin
         n_bad++;
         $display("FAIL reset_data: got key_out=%0h idx=%0d, expected 0/0", key_out, rd_index);
      end
      rst = 1'b0;
   endtask

   task automatic test_no_keys();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (error !== 1'b1 || busy !== 1'b0 || key_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL no_keys_err: got e=%b b=%b v=%b, expected 1/0/0", error, busy, key_valid);
      end
      @(negedge clk);
      n_cmp++;
      if (error !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL no_keys_pulse: got e=%b b=%b, expected 0/0", error, busy);
      end
   endtask

   task automatic test_load();
      key_rollover = 1'b1;
      @(negedge clk);
      key_rollover = 1'b0;
   endtask

   // Full sequence with key_ready held high; optionally re-pulse start mid-sequence.
   task automatic test_sequence(input bit restart_mid);
      bit ev;
      key_ready = 1'b1;
      start     = 1'b1;
      push_set();
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start = restart_mid && (c == 3 || c == 5);
         ev = (c % 2 == 0) && (c <= 8);
         n_cmp++;
         if (key_valid !== ev) begin
            n_bad++;
            $display("FAIL seq_valid c%0d: got %b, expected %b", c, key_valid, ev);
         end
         if (ev) begin
            n_cmp++;
            if (key_out !== keyfile[c/2-1]) begin
               n_bad++;
               $display("FAIL seq_key c%0d: got %0h, expected %0h", c, key_out, keyfile[c/2-1]);
            end
         end
         n_cmp++;
         if (key_last !== (c == 8) || done !== (c == 9) || busy !== (c <= 9) || error !== 1'b0) begin
            n_bad++;
            $display("FAIL seq_ctrl c%0d: got l=%b d=%b b=%b e=%b, expected l=%b d=%b b=%b e=0",
                     c, key_last, done, busy, error, c == 8, c == 9, c <= 9);
         end
      end
   endtask

   task automatic test_backpressure();
      key_ready = 1'b1;
      start     = 1'b1;
      push_set();
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c >= 4 && c <= 8) begin
            n_cmp++;
            if (key_valid !== 1'b1 || key_out !== keyfile[1] || rd_index !== 2'd1) begin
               n_bad++;
               $display("FAIL bp_hold c%0d: got v=%b key=%0h idx=%0d, expected 1/%0h/1", c, key_valid, key_out, rd_index, keyfile[1]);
            end
         end
         if (c == 9 || c == 13) begin
            n_cmp++;
            if (key_valid !== 1'b0 || done !== (c == 13)) begin
               n_bad++;
               $display("FAIL bp_after c%0d: got v=%b d=%b, expected 0/%b", c, key_valid, done, c == 13);
            end
         end
         if (c == 12) begin
            n_cmp++;
            if (key_out !== keyfile[3] || key_last !== 1'b1) begin
               n_bad++;
               $display("FAIL bp_last: got key=%0h l=%b, expected %0h/1", key_out, key_last, keyfile[3]);
            end
         end
         key_ready = !(c >= 3 && c < 8);
      end
   endtask

   task automatic test_clear();
      key_ready = 1'b1;
      start     = 1'b1;
      push_set();
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 5) key_ready = 1'b0;
      end
      n_cmp++;
      if (key_valid !== 1'b1 || key_out !== keyfile[2]) begin
         n_bad++;
         $display("FAIL clr_present: got v=%b key=%0h, expected 1/%0h", key_valid, key_out, keyfile[2]);
      end
      key_clear = 1'b1;
      @(negedge clk);
      key_clear = 1'b0;
      n_cmp++;
      if (key_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rd_index !== 2'd0) begin
         n_bad++;
         $display("FAIL clr_abort: got v=%b b=%b d=%b idx=%0d, expected 0/0/0/0", key_valid, busy, done, rd_index);
      end
      n_cmp++;
      if (sb.size() != 2) begin
         n_bad++;
         $display("FAIL clr_pending: got %0d queued, expected 2", sb.size());
      end
      sb.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (error !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         n_bad++;
         $display("FAIL clr_err: got e=%b b=%b d=%b, expected 1/0/0", error, busy, done);
      end
      // Rollover and clear together: clear wins, keys stay unloaded.
      key_rollover = 1'b1;
      key_clear    = 1'b1;
      @(negedge clk);
      key_rollover = 1'b0;
      key_clear    = 1'b0;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (error !== 1'b1 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL clr_wins: got e=%b b=%b, expected 1/0", error, busy);
      end
      key_ready = 1'b1;
   endtask

   task automatic test_rst_mid();
      key_ready = 1'b0;
      start     = 1'b1;
      push_set();
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (key_valid !== 1'b1 || key_out !== keyfile[0]) begin
         n_bad++;
         $display("FAIL rst_present: got v=%b key=%0h, expected 1/%0h", key_valid, key_out, keyfile[0]);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if (key_valid !== 1'b0 || key_out !== 32'h0 || rd_index !== 2'd0 || busy !== 1'b0 ||
          done !== 1'b0 || error !== 1'b0 || key_last !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_mid: got v=%b key=%0h idx=%0d b=%b d=%b e=%b, expected all 0",
                  key_valid, key_out, rd_index, busy, done, error);
      end
      sb.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (error !== 1'b1 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_unloaded: got e=%b b=%b, expected 1/0", error, busy);
      end
      key_ready = 1'b1;
   endtask

   initial begin
      n_cmp        = 0;
      n_bad        = 0;
      rst          = 1'b1;
      key_rollover = 1'b0;
      key_clear    = 1'b0;
      start        = 1'b0;
      key_ready    = 1'b0;
      keyfile[0]   = 32'h11111111;
      keyfile[1]   = 32'h22222222;
      keyfile[2]   = 32'h33333333;
      keyfile[3]   = 32'h44444444;
      @(negedge clk);
      test_reset();
      test_no_keys();
      test_load();
      test_sequence(1'b0);
      test_sequence(1'b1);
      test_sequence(1'b0);
      test_backpressure();
      test_clear();
      test_load();
      test_rst_mid();
      @(negedge clk);
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL sb_leftover: got %0d queued, expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
